// File: rtl/grid8_valve_pkg.sv
// Shared types, constants and the mux-line encoder for the grid8 valve sequencer.
package grid8_valve_pkg;

  typedef enum logic [1:0] {
    OP_CLOSE = 2'b00,
    OP_FLOW  = 2'b01,
    OP_SHIFT = 2'b10,
    OP_SWEEP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_HOLD   = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

  // A 1 pressurises a line, which closes the valve.
  localparam logic [5:0] C_CLOSED = 6'h3F;
  localparam logic [7:0] L_CLOSED = 8'hFF;

  // Each select bit drives a complementary pair of air lines, so exactly one
  // mux path is left open for any channel.
  function automatic logic [5:0] mux_pattern(input logic [2:0] chan);
    return {~chan[2], chan[2], ~chan[1], chan[1], ~chan[0], chan[0]};
  endfunction

endpackage

// File: rtl/grid8_dwell_counter.sv
// Loadable down-counter that parks at zero; used for the settle and dwell timers.
module grid8_dwell_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Load wins; otherwise count down and stop at zero so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/grid8_valve_sequencer.sv
// Command-driven, break-before-make valve sequencer for the 8-input cell-trap grid.
module grid8_valve_sequencer
  import grid8_valve_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [2:0]         cmd_chan,
  input  logic [2:0]         cmd_stage,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic [5:0]         c,
  output logic [7:0]         d,
  output logic [7:0]         e,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  // Settle counter holds S-1 so the closed phase lasts exactly S cycles.
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  state_t               state_reg, state_next;
  op_t                  op_reg;
  logic [2:0]           chan_reg;
  logic [2:0]           stage_reg;
  logic [DWELL_W-1:0]   dwell_m1_reg;
  logic [DWELL_W-1:0]   dwell_m1_in;
  logic [2:0]           k_reg, k_next;
  logic                 accept;
  logic                 settle_load, dwell_load;
  logic                 settle_zero, dwell_zero;
  logic [7:0]           stage_hot, k_hot;
  logic [5:0]           c_reg, c_next;
  logic [7:0]           d_reg, d_next;
  logic [7:0]           e_reg, e_next;
  logic                 done_reg, done_next;
  logic                 aborted_reg, aborted_next;

  assign cmd_ready   = (state_reg == ST_IDLE) && !abort;
  assign accept      = cmd_valid && cmd_ready;
  // A dwell of 0 behaves as 1, which is a reload value of 0 either way.
  assign dwell_m1_in = (cmd_dwell == '0) ? '0 : cmd_dwell - 1'b1;

  // One-hot lane selects for the latched stage and the upcoming sweep index.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign stage_hot[gi] = (stage_reg == 3'(gi));
    assign k_hot[gi]     = (k_next == 3'(gi));
  end

  grid8_dwell_counter #(.W(8)) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load       (settle_load),
    .load_value (SETTLE_M1),
    .zero       (settle_zero)
  );

  grid8_dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load       (dwell_load),
    .load_value (dwell_m1_reg),
    .zero       (dwell_zero)
  );

  // State and sweep index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  // Command latch; only written on acceptance so busy-time field changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg       <= OP_CLOSE;
      chan_reg     <= '0;
      stage_reg    <= '0;
      dwell_m1_reg <= '0;
    end else if (accept) begin
      op_reg       <= op_t'(cmd_op);
      chan_reg     <= cmd_chan;
      stage_reg    <= cmd_stage;
      dwell_m1_reg <= dwell_m1_in;
    end
  end

  // Next-state logic, timer loads and abort handling.
  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    settle_load  = 1'b0;
    dwell_load   = 1'b0;
    aborted_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next  = ST_SETTLE;
          k_next      = '0;
          settle_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end else if (settle_zero) begin
          state_next = ST_HOLD;
          dwell_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end else if (dwell_zero) begin
          if (op_reg == OP_SWEEP && k_reg != 3'd7) begin
            state_next  = ST_SETTLE;
            k_next      = k_reg + 3'd1;
            settle_load = 1'b1;
          end else begin
            state_next = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
        if (abort) begin
          aborted_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line pattern for the upcoming cycle: closed everywhere except in HOLD.
  always_comb begin
    c_next    = C_CLOSED;
    d_next    = L_CLOSED;
    e_next    = L_CLOSED;
    done_next = (state_next == ST_FINISH);
    if (state_next == ST_HOLD) begin
      case (op_reg)
        OP_FLOW: begin
          c_next = mux_pattern(chan_reg);
          d_next = 8'h00;
        end
        OP_SHIFT: begin
          c_next = mux_pattern(chan_reg);
          d_next = ~stage_hot;
          e_next = ~stage_hot;
        end
        OP_SWEEP: begin
          c_next = mux_pattern(chan_reg);
          e_next = ~k_hot;
        end
        default: begin
          c_next = C_CLOSED;
        end
      endcase
    end
  end

  // Registered outputs; reset forces every line closed immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg       <= C_CLOSED;
      d_reg       <= L_CLOSED;
      e_reg       <= L_CLOSED;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      c_reg       <= c_next;
      d_reg       <= d_next;
      e_reg       <= e_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
    end
  end

  assign c       = c_reg;
  assign d       = d_reg;
  assign e       = e_reg;
  assign done    = done_reg;
  assign aborted = aborted_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_grid8_valve_sequencer.sv
// Self-checking bench for grid8_valve_sequencer: vector table, corner sequences, random commands.
module tb_grid8_valve_sequencer;

  localparam int S = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [2:0]   cmd_chan;
  logic [2:0]   cmd_stage;
  logic [W-1:0] cmd_dwell;
  logic         abort;
  logic [5:0]   c;
  logic [7:0]   d;
  logic [7:0]   e;
  logic         busy;
  logic         done;
  logic         aborted;

  always #5 clk = ~clk;

  grid8_valve_sequencer #(.SETTLE_CYCLES(S), .DWELL_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_chan  (cmd_chan),
    .cmd_stage (cmd_stage),
    .cmd_dwell (cmd_dwell),
    .abort     (abort),
    .c         (c),
    .d         (d),
    .e         (e),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  // Frame = {c, d, e, cmd_ready, busy, done, aborted}
  typedef logic [25:0] frame_t;
  frame_t now_frame;
  assign now_frame = {c, d, e, cmd_ready, busy, done, aborted};

  int errors = 0;
  int checks = 0;
  frame_t exp_q[$];

  typedef struct {
    logic [1:0]   op;
    logic [2:0]   chan;
    logic [2:0]   stage;
    logic [W-1:0] dwell;
    logic [5:0]   c;
    logic [7:0]   d;
    logic [7:0]   e;
    int           done_at;
  } vec_t;
  vec_t tbl[5];

  function automatic frame_t mk(logic [5:0] cc, logic [7:0] dd, logic [7:0] ee,
                                logic r, logic b, logic dn, logic ab);
    return {cc, dd, ee, r, b, dn, ab};
  endfunction

  function automatic frame_t closed_busy();
    return mk(6'h3F, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic frame_t finish_frame();
    return mk(6'h3F, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic frame_t idle_frame();
    return mk(6'h3F, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  // Hold pattern straight from the line rules: select bit b opens c[2b] when 0
  // and c[2b+1] when 1; stage/sweep lanes open only the addressed bit.
  function automatic frame_t hold_frame(logic [1:0] op, logic [2:0] chan,
                                        logic [2:0] stage, logic [2:0] k);
    logic [5:0] cc;
    logic [7:0] dd;
    logic [7:0] ee;
    dd = 8'hFF;
    ee = 8'hFF;
    for (int b = 0; b < 3; b++) begin
      cc[2*b]   = chan[b];
      cc[2*b+1] = ~chan[b];
    end
    case (op)
      2'd0: cc = 6'h3F;
      2'd1: dd = 8'h00;
      2'd2: begin dd[stage] = 1'b0; ee[stage] = 1'b0; end
      default: ee[k] = 1'b0;
    endcase
    return mk(cc, dd, ee, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected frame list for one command, from acceptance to the done cycle.
  task automatic model_run(input logic [1:0] op, input logic [2:0] chan,
                           input logic [2:0] stage, input int dwell);
    int dd;
    int reps;
    dd   = (dwell == 0) ? 1 : dwell;
    reps = (op == 2'd3) ? 8 : 1;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < S; i++) exp_q.push_back(closed_busy());
      for (int i = 0; i < dd; i++) exp_q.push_back(hold_frame(op, chan, stage, 3'(r)));
    end
    exp_q.push_back(finish_frame());
  endtask

  task automatic expect_run(input string name);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check(name, 32'(now_frame), 32'(exp_q.pop_front()));
    end
  endtask

  // Present a command (caller sits at a negedge) and hold it until accepted.
  task automatic issue(input logic [1:0] op, input logic [2:0] chan,
                       input logic [2:0] stage, input logic [W-1:0] dwell);
    int budget;
    budget    = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_chan  = chan;
    cmd_stage = stage;
    cmd_dwell = dwell;
    #1;
    while (!cmd_ready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_chan  = 3'($urandom);
    cmd_stage = 3'($urandom);
    cmd_dwell = W'($urandom);
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check(name, 32'(now_frame), 32'(idle_frame()));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e_exp;
    int         seen;
    logic [1:0] rop;
    logic [2:0] rch, rst_g;
    int         rdw;

    tbl[0] = '{2'd1, 3'd5, 3'd0, 8'd3, 6'b011001, 8'h00, 8'hFF, 8};
    tbl[1] = '{2'd2, 3'd2, 3'd6, 8'd0, 6'b100110, 8'hBF, 8'hBF, 6};
    tbl[2] = '{2'd0, 3'd3, 3'd1, 8'd2, 6'h3F,     8'hFF, 8'hFF, 7};
    tbl[3] = '{2'd1, 3'd0, 3'd0, 8'd1, 6'h2A,     8'h00, 8'hFF, 6};
    tbl[4] = '{2'd2, 3'd7, 3'd0, 8'd2, 6'h15,     8'hFE, 8'hFE, 7};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_chan = '0;
    cmd_stage = '0; cmd_dwell = '0; abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 32'(now_frame), 32'(idle_frame()));
    rst = 1'b0;
    idle_check("post_reset_idle");

    // Vector table: closed settle, hold pattern, done at the listed cycle.
    for (int t = 0; t < 5; t++) begin
      issue(tbl[t].op, tbl[t].chan, tbl[t].stage, tbl[t].dwell);
      for (int j = 1; j <= tbl[t].done_at; j++) begin
        @(negedge clk);
        if (j <= S)
          check($sformatf("vec%0d_settle_c%0d", t, j), 32'(now_frame), 32'(closed_busy()));
        else if (j < tbl[t].done_at)
          check($sformatf("vec%0d_hold_c%0d", t, j), 32'(now_frame),
                32'(mk(tbl[t].c, tbl[t].d, tbl[t].e, 1'b0, 1'b1, 1'b0, 1'b0)));
        else
          check($sformatf("vec%0d_done_c%0d", t, j), 32'(now_frame), 32'(finish_frame()));
      end
      idle_check($sformatf("vec%0d_idle", t));
    end

    // SWEEP chan 0 dwell 2: lateral lane walks FE..7F, done at T+49.
    issue(2'd3, 3'd0, 3'd5, 8'd2);
    e_exp = 8'hFE;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < S; j++) begin
        @(negedge clk);
        check($sformatf("sweep_settle_k%0d", k), 32'(now_frame), 32'(closed_busy()));
      end
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        check($sformatf("sweep_hold_k%0d", k), 32'(now_frame),
              32'(mk(6'h2A, 8'hFF, e_exp, 1'b0, 1'b1, 1'b0, 1'b0)));
      end
      e_exp = {e_exp[6:0], 1'b1};
    end
    @(negedge clk);
    check("sweep_done_t49", 32'(now_frame), 32'(finish_frame()));
    idle_check("sweep_idle");

    // Largest dwell for the counter width holds exactly 255 cycles.
    issue(2'd1, 3'd3, 3'd0, 8'd255);
    model_run(2'd1, 3'd3, 3'd0, 255);
    expect_run("max_dwell");
    idle_check("max_dwell_idle");

    // Abort in the second HOLD cycle of FLOW dwell 10.
    issue(2'd1, 3'd1, 3'd0, 8'd10);
    repeat (S + 1) @(negedge clk);
    @(negedge clk);
    check("abort_pre_hold", 32'(now_frame), 32'(hold_frame(2'd1, 3'd1, 3'd0, 3'd0)));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_pulse", 32'(now_frame), 32'(mk(6'h3F, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1)));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || aborted || busy) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Valid with abort in IDLE: not accepted, no pulse.
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_chan = 3'd4; cmd_dwell = 8'd2; abort = 1'b1;
    #1 check("idle_abort_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0; abort = 1'b0;
    idle_check("idle_abort_no_accept");
    idle_check("idle_abort_still_idle");

    // Command presented while busy is held off, then accepted exactly once.
    issue(2'd1, 3'd6, 3'd0, 8'd2);
    model_run(2'd1, 3'd6, 3'd0, 2);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_chan = 3'd3; cmd_stage = 3'd1; cmd_dwell = 8'd1;
    expect_run("holdoff_first");
    issue(2'd2, 3'd3, 3'd1, 8'd1);
    model_run(2'd2, 3'd3, 3'd1, 1);
    expect_run("holdoff_second");
    idle_check("holdoff_idle");
    idle_check("holdoff_once");

    // Asynchronous reset in the first HOLD of a SWEEP.
    issue(2'd3, 3'd4, 3'd0, 8'd3);
    repeat (S + 1) @(negedge clk);
    check("rst_pre_hold", 32'(now_frame), 32'(hold_frame(2'd3, 3'd4, 3'd0, 3'd0)));
    #2 rst = 1'b1;
    #1 check("rst_async_closed", 32'(now_frame), 32'(idle_frame()));
    @(negedge clk);
    rst = 1'b0;
    idle_check("rst_release_idle");
    issue(2'd1, 3'd2, 3'd0, 8'd2);
    model_run(2'd1, 3'd2, 3'd0, 2);
    expect_run("rst_after_cmd");
    idle_check("rst_after_idle");

    // Random commands against the frame-list model.
    for (int n = 0; n < 20; n++) begin
      rop   = 2'($urandom_range(0, 3));
      rch   = 3'($urandom);
      rst_g = 3'($urandom);
      rdw   = int'($urandom_range(0, 5));
      issue(rop, rch, rst_g, W'(rdw));
      model_run(rop, rch, rst_g, rdw);
      expect_run($sformatf("rand%0d_op%0d", n, rop));
      idle_check($sformatf("rand%0d_idle", n));
      repeat ($urandom_range(0, 2)) idle_check($sformatf("rand%0d_gap", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid8_valve_sequencer.md
# grid8_valve_sequencer

Digital controller that drives the pneumatic control lines of the 8-input cell-trap grid device: the six multiplexer air lines and the per-stage vertical (`d`) and lateral (`e`) valve lines. It accepts commands over a valid/ready handshake and expands each one into timed valve patterns. Every pattern change is break-before-make: all valves close for a settle interval first, and the device is always left fully closed when a command completes. It sits between the host command interface and the solenoid driver board.

## Interface
- `SETTLE_CYCLES`, default 4: cycles all valves stay closed before each pattern is applied; legal range is 1 to 255.
- `DWELL_W`, default 16: width of the dwell field and the dwell counter.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: the sequencer can accept a command.
- `cmd_op` in 2: operation; 00 CLOSE, 01 FLOW, 10 SHIFT, 11 SWEEP.
- `cmd_chan` in 3: mux input select; 0 selects i1 and 7 selects i8.
- `cmd_stage` in 3: grid stage; 0 selects g1. SWEEP ignores it.
- `cmd_dwell` in DWELL_W: number of hold cycles. A value of 0 is treated as 1.
- `abort` in 1: synchronous abort.
- `c` out 6: mux air lines; `c[0]` drives c1. A 1 means pressurised, so the valve is closed.
- `d` out 8: vertical transfer lines, one per stage. A 1 means closed.
- `e` out 8: lateral transfer lines, one per stage. A 1 means closed.
- `busy` out 1: high when the FSM is not in IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse when an abort is taken.

## Operation
- Outputs while reset is asserted: `c`=6'h3F, `d`=8'hFF, `e`=8'hFF, `cmd_ready`=1, `busy`=0, `done`=0, `aborted`=0. All outputs are registered.
- Mux pattern for channel `n`, which opens exactly one path:
  - `c[0]`=n[0] and `c[1]`=~n[0].
  - `c[2]`=n[1] and `c[3]`=~n[1].
  - `c[4]`=n[2] and `c[5]`=~n[2].
- Hold patterns. Any line not listed is closed.
  - CLOSE: all lines closed.
  - FLOW: mux set to `cmd_chan`; `d`=8'h00; `e`=8'hFF.
  - SHIFT: mux set to `cmd_chan`; `d[stage]`=0 and `e[stage]`=0.
  - SWEEP: mux set to `cmd_chan`; `e[k]`=0 for the current k, with k running from 0 to 7.
- FSM states: IDLE, SETTLE, HOLD, FINISH.
  - IDLE→SETTLE on `cmd_valid && cmd_ready`. The command is latched and k is set to 0.
  - SETTLE: all lines closed. Moves to HOLD after SETTLE_CYCLES cycles.
  - HOLD: the pattern is driven for the effective dwell.
    - If the op is SWEEP and k<7: k increments and the FSM returns to SETTLE.
    - Otherwise: FINISH.
  - FINISH: all lines closed and `done`=1 for one cycle, then IDLE.
- `cmd_ready` = (state==IDLE) && !abort.
- Abort:
  - Taken in SETTLE, HOLD or FINISH: the next cycle has all lines closed, `aborted`=1, state IDLE, and no `done`.
  - In IDLE, abort is ignored, and a simultaneous `cmd_valid` is not accepted.
- Fields arriving while the FSM is busy are ignored. The latched command never changes mid-operation.
- Reset asserted mid-operation closes all lines immediately (asynchronous) and produces no done or aborted pulse.

## Timing
- Command accepted at edge T:
  - T+1 through T+S show the all-closed pattern (S=SETTLE_CYCLES).
  - The hold pattern is driven from T+S+1 for D cycles (D = effective dwell).
  - `done` is high in cycle T+S+D+1, with all lines closed.
  - `cmd_ready` returns high in cycle T+S+D+2.
- SWEEP: `done` is high at T+8(S+D)+1.
- The dwell counter is DWELL_W bits and loads D−1. It never wraps: a D of 2^DWELL_W−1 holds exactly that many cycles.
- The settle counter is 8 bits.

## Structure
- Package `grid8_valve_pkg` holds:
  - the opcode enum and the FSM state enum;
  - the all-closed constants `C_CLOSED`=6'h3F and `L_CLOSED`=8'hFF;
  - the function `mux_pattern(chan)` that returns the 6-bit `c` value.
- Sub-module `grid8_dwell_counter`: a loadable down-counter with a `zero` flag. Two instances, one for settle and one for dwell.

## Test plan
- Reset with S=4, then FLOW with chan=5, dwell=3 at edge T.
  - T+1 to T+4: outputs closed.
  - T+5 to T+7: `c`=6'b011001, `d`=00, `e`=FF.
  - T+8: `done`.
- SHIFT with chan=2, stage=6, dwell=0: the hold lasts 1 cycle with `c`=6'b100110, `d`=8'hBF, `e`=8'hBF.
- SWEEP with chan=0, dwell=2: `e` steps through FE, FD, …, 7F, each preceded by 4 closed cycles; `done` at T+49.
- Abort asserted during the 2nd HOLD cycle of FLOW with dwell=10: the next cycle is all closed with `aborted`=1, there is no `done`, and `cmd_ready`=1.
- `cmd_valid` and `abort` together in IDLE: no accept and no pulse. A command presented while busy is held off until `cmd_ready` and is accepted once.
- Asynchronous `rst` mid-HOLD of SWEEP: outputs are closed before the next edge; after release the FSM is in IDLE and the next command runs normally.
